ms_jk_bank: RTL
===============

Name: ms_jk_bank

Overview:
- Parametrised bank of WIDTH synchronous master-slave flip-flops that share one clock, one enable and one mode select.
- Each bit's next state comes from its own j/k pair, interpreted under a bank-wide mode: JK, T, D or SR.
- An optional slave stage delays the visible output by one cycle, giving master-slave semantics without latches.
- Used as a general control/status register primitive and as the building block for JK-style counters.

Parameters:
- WIDTH, 8, number of flip-flop channels.
- RST_VAL, {WIDTH{1'b0}}, value loaded into master and slave on reset.
- SLAVE_STAGE, 1: 1 means q comes from the slave register, one cycle behind master_q; 0 means q equals master_q.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  update enable for mode-driven updates.
- mode  input  2  00=JK, 01=T, 10=D, 11=SR; applies to all bits.
- j  input  WIDTH  per-bit J / T / D / S input.
- k  input  WIDTH  per-bit K / R input; ignored in T and D modes.
- load  input  1  parallel load strobe.
- load_val  input  WIDTH  parallel load data.
- err_clr  input  1  clears sr_err.
- master_q  output  WIDTH  master register.
- q  output  WIDTH  bank output.
- qb  output  WIDTH  always ~q; never X.
- sr_err  output  WIDTH  sticky per-bit flag for illegal SR input (S=R=1).

Behaviour:
- Reset: clock clk; reset rst, synchronous, active-high. On reset:
  - master = RST_VAL, slave = RST_VAL, so q = RST_VAL and qb = ~RST_VAL.
  - sr_err = 0; event counter = 0.
- Priority per clock edge: rst > load > en > hold.
- load=1: master <= load_val regardless of en, mode, j and k. No sr_err update occurs on a load cycle.
- en=1 and load=0: each bit i updates by mode.
  - JK: {j,k}=00 hold, 01 clear, 10 set, 11 toggle.
  - T: j=1 toggle, j=0 hold.
  - D: master <= j.
  - SR: 00 hold, 01 clear, 10 set. 11 holds the master bit and sets sr_err[i].
- en=0 and load=0: master holds; sr_err is not updated.
- Mode changes take effect on the same edge at which they are sampled. There is no mode pipeline.
- Slave stage (SLAVE_STAGE=1):
  - slave <= master every cycle, independent of en and load.
  - q therefore lags master_q by exactly 1 cycle.
  - On the reset edge, both master and slave load RST_VAL.
- Slave stage (SLAVE_STAGE=0): q = master_q combinationally; there is no extra register.
- sr_err: bits are sticky. err_clr=1 clears every bit. If a new illegal SR input coincides with err_clr on the same edge, the set wins for that bit.
- Reset mid-operation (e.g. during a T-mode toggle stream): the state on the next edge is RST_VAL. The pending toggle is discarded.
- The design contains no latches; all state changes on the rising edge of clk.

Optional Feature:
- Macro MS_JK_BANK_EVT_CNT_EN.
- When defined:
  - Adds output evt_cnt (16 bits).
  - evt_cnt increments on each edge where master's next value differs from its current value in at least one bit.
  - It saturates at 16'hFFFF and resets to 0 on rst.
- When undefined: the port and the counter logic are absent.

Decomposition:
- Package ms_jk_pkg holds:
  - mode enum typedef: MODE_JK, MODE_T, MODE_D, MODE_SR;
  - the 16-bit event counter width constant.
- Sub-module jk_cell: a single-bit combinational next-state function with inputs mode, j, k, cur and outputs nxt, illegal. It is instanced WIDTH times in a generate loop. The registers live in ms_jk_bank.

Test Plan (WIDTH=8, RST_VAL=8'h00, SLAVE_STAGE=1):
1. Reset: rst=1 for one edge with load=1, load_val=8'hFF -> master_q=00, q=00, qb=FF, sr_err=00.
2. JK toggle: mode=00, en=1, j=k=FF for 3 edges -> master_q=FF,00,FF and q=00,FF,00, one cycle behind.
3. JK set/clear/hold: from 00, j=0F, k=F0 -> master_q=0F. Then j=k=00 -> holds 0F. Then en=0 with j=FF, k=00 -> still 0F.
4. SR illegal:
   - mode=11, master=3C, j=k=81 -> master stays 3C, sr_err=81.
   - err_clr=1, j=k=00 -> sr_err=00.
   - err_clr=1 with j=k=01 -> sr_err=01.
5. Priority and reset mid-operation:
   - mode=01, en=1, j=FF, load=1, load_val=A5 -> master_q=A5 (not 5A).
   - Next edge: load=0 -> 5A.
   - Next edge: rst=1 with load=1 -> master_q=00, and q=00 on the same edge.
6. D mode and counter (MS_JK_BANK_EVT_CNT_EN defined): mode=10, en=1, j=3C, 3C, C3 -> master_q=3C, 3C, C3; q=3C one cycle later; evt_cnt increments 0 -> 1 -> 1 -> 2.

Source files
------------

// File: rtl/ms_jk_pkg.sv
// rtl/ms_jk_pkg.sv - shared mode encoding and event counter sizing for ms_jk_bank
package ms_jk_pkg;

  // Bank-wide interpretation of each bit's j/k pair.
  typedef enum logic [1:0] {
    MODE_JK = 2'b00,
    MODE_T  = 2'b01,
    MODE_D  = 2'b10,
    MODE_SR = 2'b11
  } mode_e;

  // Width of the optional change-event counter and its saturation value.
  localparam int unsigned          EVT_CNT_W   = 16;
  localparam logic [EVT_CNT_W-1:0] EVT_CNT_MAX = {EVT_CNT_W{1'b1}};

  // Saturating increment used by the event counter.
  function automatic logic [EVT_CNT_W-1:0] sat_inc(input logic [EVT_CNT_W-1:0] val);
    if (val == EVT_CNT_MAX) begin
      return val;
    end
    return val + 1'b1;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// rtl/jk_cell.sv - single-bit combinational next-state function for JK/T/D/SR modes
module jk_cell
  import ms_jk_pkg::*;
(
  input  logic [1:0] mode,
  input  logic       j,
  input  logic       k,
  input  logic       cur,
  output logic       nxt,
  output logic       illegal
);

  mode_e mode_s;

  assign mode_s = mode_e'(mode);

  // Decode j/k under the selected mode; SR with both inputs high holds and flags.
  always_comb begin
    nxt     = cur;
    illegal = 1'b0;
    case (mode_s)
      MODE_JK: begin
        case ({j, k})
          2'b01:   nxt = 1'b0;
          2'b10:   nxt = 1'b1;
          2'b11:   nxt = ~cur;
          default: nxt = cur;
        endcase
      end
      MODE_T: begin
        nxt = j ? ~cur : cur;
      end
      MODE_D: begin
        nxt = j;
      end
      MODE_SR: begin
        case ({j, k})
          2'b01:   nxt = 1'b0;
          2'b10:   nxt = 1'b1;
          2'b11: begin
            nxt     = cur;
            illegal = 1'b1;
          end
          default: nxt = cur;
        endcase
      end
      default: begin
        nxt     = cur;
        illegal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ms_jk_bank.sv
// rtl/ms_jk_bank.sv - bank of master-slave JK/T/D/SR flip-flops; optional evt_cnt via MS_JK_BANK_EVT_CNT_EN
module ms_jk_bank
  import ms_jk_pkg::*;
#(
  parameter int unsigned       WIDTH       = 8,
  parameter logic [WIDTH-1:0]  RST_VAL     = {WIDTH{1'b0}},
  parameter int unsigned       SLAVE_STAGE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     j,
  input  logic [WIDTH-1:0]     k,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_val,
  input  logic                 err_clr,
  output logic [WIDTH-1:0]     master_q,
  output logic [WIDTH-1:0]     q,
  output logic [WIDTH-1:0]     qb,
`ifdef MS_JK_BANK_EVT_CNT_EN
  output logic [EVT_CNT_W-1:0] evt_cnt,
`endif
  output logic [WIDTH-1:0]     sr_err
);

  logic [WIDTH-1:0] master_d;
  logic [WIDTH-1:0] master_r_q;
  logic [WIDTH-1:0] err_d;
  logic [WIDTH-1:0] err_q;
  logic [WIDTH-1:0] cell_nxt;
  logic [WIDTH-1:0] cell_ill;
  logic [WIDTH-1:0] err_set;

  // One combinational cell per bit; all state is held here in the bank.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    jk_cell u_cell (
      .mode    (mode),
      .j       (j[gi]),
      .k       (k[gi]),
      .cur     (master_r_q[gi]),
      .nxt     (cell_nxt[gi]),
      .illegal (cell_ill[gi])
    );
  end

  // Master next state: load beats a mode-driven update, otherwise hold.
  always_comb begin
    master_d = master_r_q;
    if (load) begin
      master_d = load_val;
    end else if (en) begin
      master_d = cell_nxt;
    end
  end

  // Illegal-SR flags only register on real mode-driven updates; a fresh set
  // beats err_clr on the same edge, clearing still works on load/idle cycles.
  always_comb begin
    err_set = '0;
    if (en && !load) begin
      err_set = cell_ill;
    end
    err_d = (err_clr ? {WIDTH{1'b0}} : err_q) | err_set;
  end

  // Master and error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      master_r_q <= RST_VAL;
      err_q      <= '0;
    end else begin
      master_r_q <= master_d;
      err_q      <= err_d;
    end
  end

  if (SLAVE_STAGE != 0) begin : g_slave
    logic [WIDTH-1:0] slave_q;

    // Slave follows master every cycle regardless of en/load.
    always_ff @(posedge clk) begin
      if (rst) begin
        slave_q <= RST_VAL;
      end else begin
        slave_q <= master_r_q;
      end
    end

    assign q = slave_q;
  end else begin : g_no_slave
    assign q = master_r_q;
  end

`ifdef MS_JK_BANK_EVT_CNT_EN
  logic [EVT_CNT_W-1:0] evt_cnt_d;
  logic [EVT_CNT_W-1:0] evt_cnt_q;

  // Count edges where at least one master bit changes, saturating at all-ones.
  always_comb begin
    evt_cnt_d = evt_cnt_q;
    if (master_d != master_r_q) begin
      evt_cnt_d = sat_inc(evt_cnt_q);
    end
  end

  // Event counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_cnt_q <= '0;
    end else begin
      evt_cnt_q <= evt_cnt_d;
    end
  end

  assign evt_cnt = evt_cnt_q;
`endif

  assign master_q = master_r_q;
  assign qb       = ~q;
  assign sr_err   = err_q;

endmodule
